generate_control: RTL and testbench

GENERATE_CONTROL -- requirements
Module: generate_control

---
 rtl/generate_control_pkg.sv | 24 ++
 rtl/rise_detect.sv | 18 +
 rtl/generate_control.sv | 44 ++++
 tb/tb_generate_control.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/generate_control_pkg.sv
// Shared game constants and the saturating interval-decrement helper,
// imported by the object generator and the level logic so both agree.
package generate_control_pkg;

    typedef logic [31:0] gtime_t;

    localparam gtime_t GC_INIT_TIME = 32'd50_000_000;
    localparam gtime_t GC_STEP      = 32'd5_000_000;
    localparam gtime_t GC_MIN_TIME  = 32'd10_000_000;

    // The floor+step sum is formed in 33 bits so a large floor or step can
    // neither wrap the comparison nor underflow the subtraction.
    function automatic gtime_t sat_dec(input gtime_t cur,
                                       input gtime_t step,
                                       input gtime_t floor_val);
        logic [32:0] w_lim;
        w_lim = {1'b0, floor_val} + {1'b0, step};
        if ({1'b0, cur} >= w_lim)
            return cur - step;
        else
            return floor_val;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// 0->1 edge detector: q_rise is high while d=1 and the previous sampled d was 0.
// Latency: combinational pulse against a one-cycle history; no backpressure.
// History register runs without reset so it tracks d through any reset.
module rise_detect (
    input  logic clk,
    input  logic d,
    output logic q_rise
);

    logic r_d_q;

    always_ff @(posedge clk) begin
        r_d_q <= d;
    end

    assign q_rise = d & ~r_d_q;

endmodule

// File: rtl/generate_control.sv
// Object-generation interval: loads INIT_TIME on reset, steps down by STEP per level-up.
// Latency: gene_time updates on the edge the level-up is detected; no backpressure.
// Saturates at MIN_TIME; reset wins over a simultaneous level-up.
module generate_control
    import generate_control_pkg::*;
#(
    parameter gtime_t INIT_TIME = GC_INIT_TIME,
    parameter gtime_t STEP      = GC_STEP,
    parameter gtime_t MIN_TIME  = GC_MIN_TIME
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        levelup,
    output logic [31:0] gene_time
);

    logic   w_rise;
    gtime_t r_gene_time;
    gtime_t w_next_time;

    rise_detect u_rise (
        .clk    (clk),
        .d      (levelup),
        .q_rise (w_rise)
    );

    assign w_next_time = sat_dec(r_gene_time, STEP, MIN_TIME);

    always_ff @(posedge clk) begin
        if (rst)
            r_gene_time <= INIT_TIME;
        else if (w_rise)
            r_gene_time <= w_next_time;
    end

    assign gene_time = r_gene_time;

    // Illegal parameter sets are only flagged, not handled in logic.
    always_ff @(posedge clk) begin
        assert ((MIN_TIME <= INIT_TIME) && (STEP != 32'd0))
            else $error("generate_control: need MIN_TIME <= INIT_TIME and STEP > 0");
    end

endmodule

// File: tb/tb_generate_control.sv
// Directed + random checks of generate_control against a per-edge reference model,
// on a default-parameter instance (a) and a small-parameter instance (b).
module tb_generate_control;

    logic        clk = 1'b0;
    logic        a_rst = 1'b1, a_lv = 1'b0;
    logic        b_rst = 1'b1, b_lv = 1'b0;
    logic [31:0] a_gt, b_gt;

    int n_vec = 0;
    int n_mis = 0;

    longint m_gt   [2];
    logic   m_prev [2];
    bit     b_valid = 1'b0;

    localparam longint INIT [2] = '{50_000_000, 23};
    localparam longint STP  [2] = '{5_000_000, 5};
    localparam longint MINT [2] = '{10_000_000, 10};

    always #5 clk = ~clk;

    generate_control dut_a (
        .clk       (clk),
        .rst       (a_rst),
        .levelup   (a_lv),
        .gene_time (a_gt)
    );

    generate_control #(
        .INIT_TIME (32'd23),
        .STEP      (32'd5),
        .MIN_TIME  (32'd10)
    ) dut_b (
        .clk       (clk),
        .rst       (b_rst),
        .levelup   (b_lv),
        .gene_time (b_gt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input longint exp);
        logic [31:0] e;
        e = exp[31:0];
        n_vec++;
        assert (obs === e)
            else begin
                n_mis++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
            end
    endtask

    // Reference behaviour per edge: reset loads INIT; otherwise a newly
    // sampled high level lowers the interval by STEP, never below MIN.
    task automatic model_edge(input int k, input logic r, input logic l);
        longint nxt;
        if (r)
            m_gt[k] = INIT[k];
        else if (l && !m_prev[k]) begin
            nxt = m_gt[k] - STP[k];
            m_gt[k] = (nxt < MINT[k]) ? MINT[k] : nxt;
        end
        m_prev[k] = l;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0, a_rst, a_lv);
        model_edge(1, b_rst, b_lv);
        if (b_rst) b_valid = 1'b1;
        #1;
        check("a_model", a_gt, m_gt[0]);
        if (b_valid) check("b_model", b_gt, m_gt[1]);
    endtask

    task automatic ta(input logic r, input logic l);
        a_rst = r;
        a_lv  = l;
        tick();
    endtask

    task automatic tb(input logic r, input logic l);
        b_rst = r;
        b_lv  = l;
        tick();
    endtask

    longint exp_rep [8] = '{45_000_000, 40_000_000, 35_000_000, 30_000_000,
                            25_000_000, 20_000_000, 15_000_000, 10_000_000};
    longint exp_b   [4] = '{18, 13, 10, 10};

    initial begin
        m_prev[0] = 1'b0;
        m_prev[1] = 1'b0;
        m_gt[0]   = 0;
        m_gt[1]   = 0;

        // Reset held with levelup toggling.
        ta(1'b1, 1'b1); check("rst_edge1", a_gt, 50_000_000);
        ta(1'b1, 1'b0); check("rst_edge2", a_gt, 50_000_000);
        ta(1'b1, 1'b1); check("rst_edge3", a_gt, 50_000_000);

        // Level high across reset release is not an event.
        for (int i = 0; i < 4; i++) begin
            ta(1'b0, 1'b1); check("hold_across_rst", a_gt, 50_000_000);
        end

        // Single event, level held for 10 cycles.
        ta(1'b0, 1'b0);
        ta(1'b0, 1'b1); check("single_event", a_gt, 45_000_000);
        for (int i = 0; i < 9; i++) begin
            ta(1'b0, 1'b1); check("single_held", a_gt, 45_000_000);
        end

        // Short pulse between edges is never sampled.
        ta(1'b0, 1'b0);
        a_lv = 1'b1; #2; a_lv = 1'b0;
        tick(); check("glitch_ignored", a_gt, 45_000_000);

        // Repeated events down to and holding at the floor.
        ta(1'b1, 1'b0);
        ta(1'b1, 1'b0); check("rst_mid_seq", a_gt, 50_000_000);
        ta(1'b0, 1'b0);
        for (int e = 0; e < 11; e++) begin
            ta(1'b0, 1'b1);
            check("repeat_event", a_gt, (e < 8) ? exp_rep[e] : 64'd10_000_000);
            ta(1'b0, 1'b1);
            ta(1'b0, 1'b0);
            ta(1'b0, 1'b0);
        end

        // Reset coinciding with a rising level at 20M.
        ta(1'b1, 1'b0);
        ta(1'b0, 1'b0);
        for (int e = 0; e < 6; e++) begin
            ta(1'b0, 1'b1);
            ta(1'b0, 1'b0);
        end
        check("reach_20M", a_gt, 20_000_000);
        ta(1'b1, 1'b1); check("rst_beats_event", a_gt, 50_000_000);
        ta(1'b0, 1'b1); check("no_event_after_simul", a_gt, 50_000_000);

        // Non-multiple floor on the small instance.
        tb(1'b1, 1'b0); check("b_reset", b_gt, 23);
        tb(1'b0, 1'b0);
        for (int e = 0; e < 4; e++) begin
            tb(1'b0, 1'b1); check("b_step", b_gt, exp_b[e]);
            tb(1'b0, 1'b0);
        end

        // Random levels with occasional resets on both instances.
        for (int i = 0; i < 600; i++) begin
            a_rst = ($urandom_range(0, 49) == 0);
            b_rst = ($urandom_range(0, 29) == 0);
            a_lv  = ($urandom_range(0, 2) != 0);
            b_lv  = $urandom_range(0, 1) != 0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
